muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the architectural HI/LO pair.
// Uses a shift-add multiplier and a restoring divider, one bit per cycle, with sign fix-up at the end.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_div;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic               w_rem_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_mt_ok;

    assign w_is_div   = r_op[1];
    assign w_signed   = r_op[0];
    assign w_abs_a    = (w_signed && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
    assign w_abs_b    = (w_signed && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;
    assign w_div_zero = w_is_div && (r_b == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply step: conditional add into the upper half, then shift right keeping the carry.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: the shifted remainder needs one extra bit before the compare.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_sub  = w_rem_sh - {1'b0, r_opnd};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_opnd});
    assign w_div_next = w_rem_ge ? {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                 : {w_rem_sh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

    assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quot_fix = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    assign w_mt_ok    = (r_state == S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_PREP;
            S_PREP: w_state_next = w_div_zero ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        case (r_state)
            S_PREP, S_CALC, S_FIX: busy = 1'b1;
            S_DONE: begin
                done        = 1'b1;
                div_by_zero = r_dbz;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dbz   <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_mt_ok && hi_we) r_hi <= wdata;
            if (w_mt_ok && lo_we) r_lo <= wdata;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= a;
                        r_b  <= b;
                    end
                end
                S_PREP: begin
                    r_neg_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= w_signed & r_a[WIDTH-1];
                    r_cnt   <= '0;
                    // Multiply: opnd=multiplicand, acc low=multiplier. Divide: opnd=divisor, acc low=dividend.
                    r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    r_dbz   <= w_div_zero;
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (w_is_div) begin
                        r_lo <= w_quot_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_lo <= w_prod_fix[WIDTH-1:0];
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                S_DONE: r_dbz <= 1'b0;
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: each scenario task drives one operation and checks results inline.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    // Issues one operation (start in cycle 0) and watches it to done.
    // inj_kind 1: extra start pulse in cycle inj_cyc; 2: MTHI of 0x55 in cycle inj_cyc.
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int inj_cyc, input int inj_kind,
                          output int lat, output int busy_bad, output logic dbz_o,
                          output logic [31:0] hi_mid);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        lat = -1; busy_bad = 0; dbz_o = 1'b0; hi_mid = '0;
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            @(negedge clk);
            start = 1'b0; hi_we = 1'b0;
            if (done) begin
                lat = c;
                dbz_o = div_by_zero;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
            if (c == inj_cyc + 1) hi_mid = hi;
            if (c == inj_cyc && inj_kind == 1) begin
                start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
            end
            if (c == inj_cyc && inj_kind == 2) begin
                hi_we = 1'b1; wdata = 32'h55;
            end
        end
        $display("op=%b a=%h b=%h latency=%0d hi=%h lo=%h dbz=%b", op_i, a_i, b_i, lat, hi, lo, dbz_o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_arith(input string name, input logic [1:0] op_i, input logic [31:0] a_i,
                              input logic [31:0] b_i, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, bb;
        logic dz;
        logic [31:0] hm;
        run_op(op_i, a_i, b_i, 0, 0, lat, bb, dz, hm);
        total_cnt++; if (lat !== 35) $display("FAIL %s_latency got %0d want 35", name, lat); else pass_cnt++;
        total_cnt++; if (bb !== 0) $display("FAIL %s_busy got %0d bad cycles want 0", name, bb); else pass_cnt++;
        total_cnt++; if (hi !== exp_hi) $display("FAIL %s_hi got %h want %h", name, hi, exp_hi); else pass_cnt++;
        total_cnt++; if (lo !== exp_lo) $display("FAIL %s_lo got %h want %h", name, lo, exp_lo); else pass_cnt++;
        total_cnt++; if (dz !== 1'b0) $display("FAIL %s_dbz got %b want 0", name, dz); else pass_cnt++;
    endtask

    task automatic test_div_zero();
        int lat, bb;
        logic dz;
        logic [31:0] hm;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(negedge clk); lo_we = 1'b0;
        total_cnt++; if (hi !== 32'h11) $display("FAIL mthi got %h want 00000011", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h22) $display("FAIL mtlo got %h want 00000022", lo); else pass_cnt++;
        run_op(2'b10, 32'd7, 32'd0, 0, 0, lat, bb, dz, hm);
        total_cnt++; if (lat !== 2) $display("FAIL dz_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (dz !== 1'b1) $display("FAIL dz_flag got %b want 1", dz); else pass_cnt++;
        total_cnt++; if (hi !== 32'h11) $display("FAIL dz_hi got %h want 00000011", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h22) $display("FAIL dz_lo got %h want 00000022", lo); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL dz_clear got %b want 0", div_by_zero); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL dz_done_pulse got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int lat, bb, late_busy;
        logic dz;
        logic [31:0] hm;
        run_op(2'b00, 32'd3, 32'd4, 10, 1, lat, bb, dz, hm);
        total_cnt++; if (lat !== 35) $display("FAIL ign_latency got %0d want 35", lat); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL ign_hi got %h want 00000000", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd12) $display("FAIL ign_lo got %h want 0000000c", lo); else pass_cnt++;
        late_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        total_cnt++; if (late_busy !== 0) $display("FAIL ign_noqueue got %0d active cycles want 0", late_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat, bb;
        logic dz;
        logic [31:0] hm;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFFFFFD; b = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL rstmid_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'h0) $display("FAIL rstmid_lo got %h want 0", lo); else pass_cnt++;
        $display("reset asserted in cycle 20 of MULT");
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, 0, 0, lat, bb, dz, hm);
        total_cnt++; if (lat !== 35) $display("FAIL rstmid_rerun_latency got %0d want 35", lat); else pass_cnt++;
        total_cnt++; if (lo !== 32'hFFFFFFF1) $display("FAIL rstmid_rerun_lo got %h want fffffff1", lo); else pass_cnt++;
    endtask

    task automatic test_mt_busy();
        int lat, bb;
        logic dz;
        logic [31:0] hm;
        @(negedge clk); hi_we = 1'b1; wdata = 32'hAB;
        @(negedge clk); hi_we = 1'b0;
        total_cnt++; if (hi !== 32'hAB) $display("FAIL mt_pre got %h want 000000ab", hi); else pass_cnt++;
        run_op(2'b00, 32'd2, 32'd3, 5, 2, lat, bb, dz, hm);
        total_cnt++; if (hm !== 32'hAB) $display("FAIL mt_busy_hi got %h want 000000ab", hm); else pass_cnt++;
        total_cnt++; if (hi !== 32'h0) $display("FAIL mt_res_hi got %h want 00000000", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd6) $display("FAIL mt_res_lo got %h want 00000006", lo); else pass_cnt++;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h55;
        @(negedge clk); hi_we = 1'b0;
        total_cnt++; if (hi !== 32'h55) $display("FAIL mt_idle_hi got %h want 00000055", hi); else pass_cnt++;
        $display("MTHI 0x55 in IDLE -> hi=%h", hi);
    endtask

    initial begin
        test_reset();
        test_arith("multu", 2'b00, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        test_arith("mult",  2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        test_arith("div",   2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_arith("divu",  2'b10, 32'd100,      32'd7, 32'd2,        32'd14);
        test_arith("divovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_mt_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
